// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  // Width of a chip-select index; never narrower than one bit.
  function automatic int unsigned cs_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Control-side handshake plus SPI pins of the parametrised SPI master.
interface spi_master_param_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_CS = 1
);
  localparam int unsigned CS_W = spi_pkg::cs_width(NUM_CS);

  logic              start;
  logic [DATA_W-1:0] din;
  logic [1:0]        mode;
  logic [CS_W-1:0]   cs_sel;
  logic              miso;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] dout;
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  start, din, mode, cs_sel, miso,
    output busy, done, dout, sclk, mosi, cs_n
  );

  modport slave (
    output start, din, mode, cs_sel, miso,
    input  busy, done, dout, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_clkgen.sv
// SCLK divider: phase counter, sclk toggling in XFER, lead/trail edge strobes.
module spi_clkgen #(
  parameter  int unsigned CLK_DIV = 2,
  localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  input  logic             cpol,
  output logic             sclk,
  output logic             tick_c,
  output logic             lead_c,
  output logic             trail_c
);

  logic [DIV_W-1:0] cnt;

  assign tick_c  = (cnt == '0);
  assign lead_c  = en && tick_c && (sclk == cpol);
  assign trail_c = en && tick_c && (sclk != cpol);

  // Counter reloads at every phase boundary, so sclk never sees a wrap glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (load)
        cnt <= load_val;
      else if (tick_c)
        cnt <= DIV_W'(CLK_DIV - 1);
      else
        cnt <= cnt - DIV_W'(1);

      if (!en)
        sclk <= cpol;
      else if (tick_c)
        sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with runtime CPOL/CPHA and busy/done handshake.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NUM_CS  = 1
) (
  input logic               clk,
  input logic               rst,
  spi_master_param_if.master bus
);

  localparam int unsigned CS_W  = cs_width(NUM_CS);
  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  spi_state_e        state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BIT_W-1:0]  bit_cnt;

  logic              accept_c;
  logic              last_bit_c;
  logic              shift_c;
  logic              sample_c;
  logic              load_c;
  logic [DIV_W-1:0]  load_val_c;
  logic              cpol_c;
  logic              tick_c;
  logic              lead_c;
  logic              trail_c;
  logic [NUM_CS-1:0] cs_dec_c;

  assign accept_c   = (state == IDLE) && bus.start;
  assign last_bit_c = (bit_cnt == BIT_W'(DATA_W - 1));
  assign shift_c    = mode_q[CPHA_BIT] ? lead_c : (trail_c && !last_bit_c);
  assign sample_c   = mode_q[CPHA_BIT] ? trail_c : lead_c;
  assign cpol_c     = accept_c ? bus.mode[CPOL_BIT] : mode_q[CPOL_BIT];

  // HOLD loads one extra count so done lands one edge after the hold period.
  assign load_c     = accept_c || ((state == XFER) && trail_c && last_bit_c);
  assign load_val_c = accept_c ? DIV_W'(CLK_DIV - 1) : DIV_W'(CLK_DIV);

  // Out-of-range index leaves every select deasserted.
  always_comb begin
    cs_dec_c = '1;
    for (int i = 0; i < int'(NUM_CS); i++) begin
      if (bus.cs_sel == CS_W'(i))
        cs_dec_c[i] = 1'b0;
    end
  end

  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (load_val_c),
    .en       (state == XFER),
    .cpol     (cpol_c),
    .sclk     (bus.sclk),
    .tick_c   (tick_c),
    .lead_c   (lead_c),
    .trail_c  (trail_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_rst();
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SETUP;
            bus.busy  <= 1'b1;
            mode_q    <= bus.mode;
            bus.cs_n  <= cs_dec_c;
            bit_cnt   <= '0;
            if (bus.mode[CPHA_BIT]) begin
              tx_sr    <= bus.din;
              bus.mosi <= 1'b0;
            end else begin
              tx_sr    <= bus.din << 1;
              bus.mosi <= bus.din[DATA_W-1];
            end
          end
        end
        SETUP: begin
          if (tick_c)
            state <= XFER;
        end
        XFER: begin
          if (shift_c) begin
            bus.mosi <= tx_sr[DATA_W-1];
            tx_sr    <= tx_sr << 1;
          end
          if (sample_c)
            rx_sr <= {rx_sr[DATA_W-2:0], bus.miso};
          if (trail_c) begin
            if (last_bit_c)
              state <= HOLD;
            else
              bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        HOLD: begin
          if (tick_c) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.cs_n <= '1;
            bus.dout <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  task automatic busy_rst();
    bus.busy <= 1'b0;
    bus.done <= 1'b0;
    bus.dout <= '0;
    bus.mosi <= 1'b0;
    bus.cs_n <= '1;
    mode_q   <= '0;
    tx_sr    <= '0;
    rx_sr    <= '0;
    bit_cnt  <= '0;
  endtask

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param: loopback, slave model, CS decode, handshake, reset abort.
module tb_spi_master_param;

  localparam int unsigned DW  = 12;
  localparam int unsigned CD  = 2;
  localparam int          LAT = (2 * DW + 2) * CD + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DW), .NUM_CS(1)) if0 ();
  spi_master_param_if #(.DATA_W(DW), .NUM_CS(4)) if1 ();

  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(1)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  spi_master_param #(.DATA_W(DW), .CLK_DIV(CD), .NUM_CS(4)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  logic          loop_en  = 1'b1;
  logic          slave_en = 1'b0;
  logic [DW-1:0] slave_sr = '0;
  int n_pass = 0, n_chk = 0;
  int rises0 = 0, mosi_hi = 0, done_cnt0 = 0;

  assign if0.miso = loop_en ? if0.mosi : slave_sr[DW-1];
  assign if1.miso = if1.mosi;

  // Mode-0 slave: shifts out on falling sclk, first bit ready before the first rise.
  always @(negedge if0.sclk) if (slave_en) slave_sr <= slave_sr << 1;
  always @(posedge if0.sclk) begin
    rises0 <= rises0 + 1;
    if (slave_en && if0.mosi) mosi_hi <= mosi_hi + 1;
  end
  always @(negedge clk) if (if0.done) done_cnt0 <= done_cnt0 + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Waits at falling edges for done on dut0; lat counts rising edges since the accept edge.
  task automatic wait_done0(input logic cs_exp, output int lat, output int cs_bad);
    lat = 0;
    cs_bad = 0;
    while (!if0.done && lat < LAT + 20) begin
      if (if0.cs_n !== cs_exp) cs_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic xfer0(input logic [DW-1:0] d, input logic [1:0] m, input logic cs,
                       input string tag, output logic [DW-1:0] got);
    int lat, cs_bad;
    @(negedge clk);
    if0.din = d; if0.mode = m; if0.cs_sel = cs; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    chk({tag, " setup_sclk"}, 32'(if0.sclk), 32'(m[1]));
    chk({tag, " setup_mosi"}, 32'(if0.mosi), m[0] ? 32'd0 : 32'(d[DW-1]));
    wait_done0(cs, lat, cs_bad);
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " cs_during"}, 32'(cs_bad), 32'd0);
    chk({tag, " busy_at_done"}, 32'(if0.busy), 32'd0);
    chk({tag, " cs_after"}, 32'(if0.cs_n), 32'd1);
    got = if0.dout;
    @(negedge clk);
    chk({tag, " idle_sclk"}, 32'(if0.sclk), 32'(m[1]));
  endtask

  initial begin
    logic [DW-1:0] got;
    int lat, cs_bad, r0, dc;
    if0.start = 1'b0; if0.din = '0; if0.mode = '0; if0.cs_sel = '0;
    if1.start = 1'b0; if1.din = '0; if1.mode = '0; if1.cs_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(if0.busy), 32'd0);
    chk("rst done", 32'(if0.done), 32'd0);
    chk("rst dout", 32'(if0.dout), 32'd0);
    chk("rst sclk", 32'(if0.sclk), 32'd0);
    chk("rst mosi", 32'(if0.mosi), 32'd0);
    chk("rst cs_n", 32'(if0.cs_n), 32'd1);
    chk("rst cs_n4", 32'(if1.cs_n), 32'hF);
    rst = 1'b0;

    r0 = rises0;
    xfer0(12'h0F5, 2'd0, 1'b0, "m0", got);
    chk("m0 dout", 32'(got), 32'h0F5);
    chk("m0 rises", 32'(rises0 - r0), 32'd12);

    loop_en = 1'b0; slave_sr = 12'h3C1; slave_en = 1'b1; r0 = mosi_hi;
    xfer0(12'hFFF, 2'd0, 1'b0, "slv", got);
    slave_en = 1'b0; loop_en = 1'b1;
    chk("slv dout", 32'(got), 32'h3C1);
    chk("slv mosi_hi", 32'(mosi_hi - r0), 32'd12);

    for (int m = 1; m < 4; m++) begin
      xfer0(12'hA5C, 2'(m), 1'b0, $sformatf("m%0d", m), got);
      chk($sformatf("m%0d dout", m), 32'(got), 32'hA5C);
    end

    xfer0(12'h321, 2'd0, 1'b1, "cs_oor", got);
    chk("cs_oor dout", 32'(got), 32'h321);

    @(negedge clk);
    if1.din = 12'hA5C; if1.mode = 2'd0; if1.cs_sel = 2'd2; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("cs4 sel2", 32'(if1.cs_n), 32'hB);
    lat = 10;
    while (!if1.done && lat < LAT + 20) begin @(negedge clk); lat++; end
    chk("cs4 latency", 32'(lat), 32'(LAT));
    chk("cs4 dout", 32'(if1.dout), 32'hA5C);
    chk("cs4 cs_after", 32'(if1.cs_n), 32'hF);

    // Start held high: exactly one idle cycle between back-to-back transfers.
    @(negedge clk);
    if0.din = 12'h3C3; if0.mode = 2'd0; if0.cs_sel = 1'b0; if0.start = 1'b1;
    @(negedge clk);
    wait_done0(1'b0, lat, cs_bad);
    chk("b2b lat1", 32'(lat), 32'(LAT));
    chk("b2b busy_gap", 32'(if0.busy), 32'd0);
    @(negedge clk);
    if0.start = 1'b0;
    chk("b2b reaccept", 32'(if0.busy), 32'd1);
    wait_done0(1'b0, lat, cs_bad);
    chk("b2b lat2", 32'(lat), 32'(LAT));
    chk("b2b dout", 32'(if0.dout), 32'h3C3);

    @(negedge clk);
    dc = done_cnt0;
    if0.din = 12'h0F0; if0.mode = 2'd0; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (20) @(negedge clk);
    if0.din = 12'hFFF; if0.mode = 2'd3; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    lat = 21;
    while (!if0.done && lat < LAT + 20) begin @(negedge clk); lat++; end
    chk("ign latency", 32'(lat), 32'(LAT));
    chk("ign dout", 32'(if0.dout), 32'h0F0);
    repeat (70) @(negedge clk);
    chk("ign one_done", 32'(done_cnt0 - dc), 32'd1);
    chk("ign idle", 32'(if0.busy), 32'd0);

    @(negedge clk);
    if0.din = 12'h5A5; if0.mode = 2'd2; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (20) @(negedge clk);
    dc = done_cnt0;
    #2 rst = 1'b1;
    #1;
    chk("abort cs_n", 32'(if0.cs_n), 32'd1);
    chk("abort sclk", 32'(if0.sclk), 32'd0);
    chk("abort busy", 32'(if0.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    chk("abort no_done", 32'(done_cnt0 - dc), 32'd0);
    chk("abort dout", 32'(if0.dout), 32'd0);
    xfer0(12'h5A3, 2'd0, 1'b0, "post", got);
    chk("post dout", 32'(got), 32'h5A3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
